wr_burst_ctrl: RTL

Write-path burst packer between the user write port and the DDR2 controller write interface; it mirrors the read FIFO on the return path. User data words are buffered in an internal single-clock FIFO. Once one full burst of WRITE_BURST words is queued, the block requests the controller, waits for acknowledge, then streams the burst with no gaps and advances the burst address.

---
 rtl/wr_burst_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/wr_burst_ctrl.sv
// wr_burst_ctrl: FIFO-buffered DDR2 write burst packer; WR_BURST_CNT_EN adds a completed-burst counter
module wr_burst_ctrl #(
    parameter int DATA_WIDTH  = 128,
    parameter int WRITE_BURST = 8,
    parameter int FIFO_DEPTH  = 32,
    parameter int ADDR_WIDTH  = 25
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         wr_fifo_in,
    input  logic                          wr_fifo_vd,
    input  logic                          addr_load,
    input  logic [ADDR_WIDTH-1:0]         addr_in,
    input  logic                          wr_ack,
    output logic                          wr_req,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [DATA_WIDTH-1:0]         wr_data_out,
    output logic                          wr_data_vd,
    output logic                          full,
    output logic                          almost_full,
    output logic                          empty,
    output logic                          overflow,
`ifdef WR_BURST_CNT_EN
    output logic [31:0]                   burst_cnt,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(WRITE_BURST);

    typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  req_q, vd_q, full_q, af_q, empty_q, ovf_q;
    logic                  wr_en, rd_en;

    // next state: the acknowledge edge pops the first beat, SEND pops the remaining ones
    always_comb begin
        wr_en   = wr_fifo_vd && !full_q;
        rd_en   = 1'b0;
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (addr_load) addr_d = addr_in;
                if (count_q >= CW'(WRITE_BURST)) state_d = REQ;
            end
            REQ: if (wr_ack) begin
                rd_en   = 1'b1;
                beat_d  = BW'(1);
                state_d = SEND;
            end
            SEND: begin
                rd_en  = 1'b1;
                beat_d = beat_q + BW'(1);
                if (&beat_q) begin
                    state_d = IDLE;
                    addr_d  = addr_q + ADDR_WIDTH'(WRITE_BURST);
                end
            end
            default: state_d = IDLE;
        endcase
        count_d = count_q + CW'(wr_en) - CW'(rd_en);
    end

    // state, pointers, flags and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            req_q   <= 1'b0;
            vd_q    <= 1'b0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_q + PW'(wr_en);
            rptr_q  <= rptr_q + PW'(rd_en);
            count_q <= count_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            if (rd_en) data_q <= mem[rptr_q];
            req_q   <= state_d == REQ;
            vd_q    <= rd_en;
            full_q  <= count_d == CW'(FIFO_DEPTH);
            af_q    <= count_d >= CW'(FIFO_DEPTH - WRITE_BURST);
            empty_q <= count_d == '0;
            ovf_q   <= ovf_q | (wr_fifo_vd & full_q);
        end
    end

    // buffer storage needs no reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_q] <= wr_fifo_in;
    end

`ifdef WR_BURST_CNT_EN
    logic [31:0] bcnt_q;

    // counts bursts on their last beat
    always_ff @(posedge clk) begin
        if (reset) bcnt_q <= '0;
        else if (state_q == SEND && &beat_q) bcnt_q <= bcnt_q + 32'd1;
    end

    assign burst_cnt = bcnt_q;
`endif

    assign wr_req      = req_q;
    assign wr_addr     = addr_q;
    assign wr_data_out = data_q;
    assign wr_data_vd  = vd_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign empty       = empty_q;
    assign overflow    = ovf_q;
    assign fifo_count  = count_q;
endmodule
